// File: rtl/gb_alu16_seq.sv
// 16-bit op sequencer for the 8-bit gb_alu: runs ADD HL,rr / ADD SP,e8 / INC rr / DEC rr
// as a low-byte op followed by a carry-chained high-byte op, then reports result and flags.
module gb_alu16_seq #(
  parameter int         ALU_LAT = 1,
  parameter logic [5:0] NOP_OP  = 6'd19
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op16,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [3:0]  flags_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  flags_out,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [5:0]  alu_op,
  output logic        alu_c_in,
  input  logic [7:0]  alu_r,
  input  logic [3:0]  alu_znhc
);

  localparam logic [1:0] OP_ADD_HL = 2'd0;
  localparam logic [1:0] OP_ADD_SP = 2'd1;
  localparam logic [1:0] OP_INC16  = 2'd2;
  localparam logic [1:0] OP_DEC16  = 2'd3;

  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_ADC = 6'd1;
  localparam logic [5:0] ALU_SUB = 6'd2;
  localparam logic [5:0] ALU_SBC = 6'd3;

  localparam int            CW      = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  // The ALU output lags its inputs by ALU_LAT cycles, so the low byte is held one
  // cycle longer than ALU_LAT to sample its result; the high-byte result is read in FIN.
  localparam logic [CW-1:0] LO_LAST = CW'(ALU_LAT);
  localparam logic [CW-1:0] HI_LAST = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    op_reg, op_next;
  logic [15:0]   a_reg, a_next;
  logic [15:0]   b_reg, b_next;
  logic [3:0]    fin_reg, fin_next;
  logic [7:0]    lo_r_reg, lo_r_next;
  logic [3:0]    lo_f_reg, lo_f_next;
  logic [15:0]   result_reg, result_next;
  logic [3:0]    flags_reg, flags_next;
  logic [7:0]    alu_a_reg, alu_a_next;
  logic [7:0]    alu_b_reg, alu_b_next;
  logic [5:0]    alu_op_reg, alu_op_next;
  logic          alu_c_reg, alu_c_next;

  logic [7:0]    e8_sext;
  logic [7:0]    hi_b;
  logic [15:0]   fin_result;
  logic [3:0]    fin_flags;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_sext
      assign e8_sext[gi] = b_reg[7];
    end
  endgenerate

  assign fin_result = {alu_r, lo_r_reg};

  always_comb begin
    hi_b = 8'h00;
    case (op_reg)
      OP_ADD_HL: hi_b = b_reg[15:8];
      OP_ADD_SP: hi_b = e8_sext;
      default:   hi_b = 8'h00;
    endcase
  end

  // alu_znhc carries the high-byte flags during FIN.
  always_comb begin
    fin_flags = fin_reg;
    case (op_reg)
      OP_ADD_HL: fin_flags = {fin_reg[3], 1'b0, alu_znhc[1], alu_znhc[0]};
      OP_ADD_SP: fin_flags = {2'b00, lo_f_reg[1], lo_f_reg[0]};
      default:   fin_flags = fin_reg;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    fin_next    = fin_reg;
    lo_r_next   = lo_r_reg;
    lo_f_next   = lo_f_reg;
    result_next = result_reg;
    flags_next  = flags_reg;
    alu_a_next  = alu_a_reg;
    alu_b_next  = alu_b_reg;
    alu_op_next = alu_op_reg;
    alu_c_next  = alu_c_reg;

    case (state_reg)
      S_IDLE, S_FIN: begin
        state_next  = S_IDLE;
        alu_op_next = NOP_OP;
        if (state_reg == S_FIN) begin
          result_next = fin_result;
          flags_next  = fin_flags;
        end
        if (start) begin
          op_next    = op16;
          a_next     = opa;
          b_next     = opb;
          fin_next   = flags_in;
          cnt_next   = '0;
          alu_a_next = opa[7:0];
          alu_b_next = (op16 == OP_INC16 || op16 == OP_DEC16) ? 8'h01 : opb[7:0];
          alu_op_next = (op16 == OP_DEC16) ? ALU_SUB : ALU_ADD;
          alu_c_next = 1'b0;
          state_next = S_LO;
        end
      end
      S_LO: begin
        if (cnt_reg == LO_LAST) begin
          lo_r_next   = alu_r;
          lo_f_next   = alu_znhc;
          alu_a_next  = a_reg[15:8];
          alu_b_next  = hi_b;
          alu_op_next = (op_reg == OP_DEC16) ? ALU_SBC : ALU_ADC;
          alu_c_next  = alu_znhc[0];
          cnt_next    = '0;
          state_next  = S_HI;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_HI: begin
        if (cnt_reg == HI_LAST) begin
          alu_op_next = NOP_OP;
          cnt_next    = '0;
          state_next  = S_FIN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      op_reg     <= 2'd0;
      a_reg      <= 16'h0000;
      b_reg      <= 16'h0000;
      fin_reg    <= 4'h0;
      lo_r_reg   <= 8'h00;
      lo_f_reg   <= 4'h0;
      result_reg <= 16'h0000;
      flags_reg  <= 4'h0;
      alu_a_reg  <= 8'h00;
      alu_b_reg  <= 8'h00;
      alu_op_reg <= NOP_OP;
      alu_c_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      fin_reg    <= fin_next;
      lo_r_reg   <= lo_r_next;
      lo_f_reg   <= lo_f_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
      alu_a_reg  <= alu_a_next;
      alu_b_reg  <= alu_b_next;
      alu_op_reg <= alu_op_next;
      alu_c_reg  <= alu_c_next;
    end
  end

  assign busy      = (state_reg == S_LO) || (state_reg == S_HI);
  assign done      = (state_reg == S_FIN);
  assign result    = done ? fin_result : result_reg;
  assign flags_out = done ? fin_flags : flags_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_op    = alu_op_reg;
  assign alu_c_in  = alu_c_reg;

endmodule
